vga_ctrl_regs: RTL and testbench

//  Parametrised Wishbone slave register file for the VGA subsystem. Replaces hard-coded

---
 rtl/vga_ctrl_regs.sv | 198 +++++++++++++++++++
 tb/tb_vga_ctrl_regs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : vga_ctrl_regs
// Brief    : Wishbone register file for the VGA subsystem. Optional shadow
//            registers commit at vsync start. Raises a vblank interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module vga_ctrl_regs #(
    parameter int                  NREGS       = 8,
    parameter int                  AW          = 12,
    parameter logic [NREGS*32-1:0] RESET_VALS  = '0,
    parameter logic [NREGS-1:0]    SHADOW_MASK = '0,
    parameter bit                  VS_POL      = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [AW-1:0]         wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    input  logic                  vs_async,
    output logic [NREGS*32-1:0]   regs_o,
    output logic                  irq_o
);
    localparam int                 c_idx_w      = AW - 2;
    localparam int                 c_sel_w      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [c_idx_w-1:0] c_idx_status = c_idx_w'(NREGS);
    localparam logic [c_idx_w-1:0] c_idx_irqen  = c_idx_w'(NREGS + 1);
    localparam logic               c_vs_idle    = ~VS_POL;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;

    logic [c_idx_w-1:0]  w_idx;
    logic [c_sel_w-1:0]  w_ridx;
    logic                w_is_cfg;
    logic                w_wr_cfg;
    logic                w_w1c;
    logic                w_wr_irqen;
    logic                w_unused;

    logic                r_vs_s1;
    logic                r_vs_s2;
    logic                r_vs_s3;
    logic                w_vs_act;
    logic                w_vstart;

    logic [31:0]         r_pend [NREGS];
    logic [31:0]         r_act  [NREGS];
    logic [NREGS-1:0]    r_dirty;
    logic                r_vblank;
    logic [15:0]         r_frame;
    logic                r_irq_en;
    logic                r_irq;
    logic [31:0]         r_dat;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;

    // ---------------- bus handshake FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        wb_stall_o  = 1'b0;
        wb_ack_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                wb_stall_o  = 1'b1;
                wb_ack_o    = wb_cyc_i;   // master may abandon the cycle
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- address decode ----------------
    assign w_idx      = wb_adr_i[AW-1:2];
    assign w_ridx     = w_idx[c_sel_w-1:0];
    assign w_is_cfg   = (w_idx < c_idx_w'(NREGS));
    assign w_wr_cfg   = w_accept && wb_we_i && w_is_cfg;
    assign w_w1c      = w_accept && wb_we_i && (w_idx == c_idx_status)
                        && wb_sel_i[0] && wb_dat_i[0];
    assign w_wr_irqen = w_accept && wb_we_i && (w_idx == c_idx_irqen) && wb_sel_i[0];
    assign w_unused   = ^wb_adr_i[1:0];

    // ---------------- vsync synchroniser and edge detect ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vs_s1 <= c_vs_idle;
            r_vs_s2 <= c_vs_idle;
            r_vs_s3 <= c_vs_idle;
        end else begin
            r_vs_s1 <= vs_async;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
        end
    end

    assign w_vs_act = (r_vs_s2 == VS_POL);
    assign w_vstart = w_vs_act && (r_vs_s3 != VS_POL);

    // ---------------- configuration registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREGS; k++) r_pend[k] <= RESET_VALS[32*k +: 32];
        end else if (w_wr_cfg) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) r_pend[w_ridx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // Commit samples pending before any same-edge write lands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREGS; k++) r_act[k] <= RESET_VALS[32*k +: 32];
        end else if (w_vstart) begin
            for (int k = 0; k < NREGS; k++) begin
                if (SHADOW_MASK[k] && r_dirty[k]) r_act[k] <= r_pend[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dirty <= '0;
        end else begin
            if (w_vstart) r_dirty <= '0;
            if (w_wr_cfg && SHADOW_MASK[w_ridx]) r_dirty[w_ridx] <= 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_regs_o
            assign regs_o[32*k +: 32] = SHADOW_MASK[k] ? r_act[k] : r_pend[k];
        end
    endgenerate

    // ---------------- status, interrupt ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vblank <= 1'b0;
            r_frame  <= 16'd0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_vstart) begin
                r_vblank <= 1'b1;
                r_frame  <= r_frame + 16'd1;
            end else if (w_w1c) begin
                r_vblank <= 1'b0;
            end
            if (w_wr_irqen) r_irq_en <= wb_dat_i[0];
            r_irq <= r_vblank & r_irq_en;
        end
    end

    assign w_status = {r_frame, 13'd0, w_vs_act, |r_dirty, r_vblank};

    // ---------------- read path ----------------
    always_comb begin
        w_rdata = '0;
        if (w_is_cfg)                   w_rdata = r_pend[w_ridx];
        else if (w_idx == c_idx_status) w_rdata = w_status;
        else if (w_idx == c_idx_irqen)  w_rdata = {31'd0, r_irq_en};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_dat <= '0;
        else if (w_accept) r_dat <= w_rdata;
    end

    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_ctrl_regs
// Brief    : Randomised self-checking bench for vga_ctrl_regs against a
//            transaction-level register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_ctrl_regs;
    localparam int             NR      = 8;
    localparam int             AW      = 12;
    localparam logic [NR-1:0]  SHADOW  = 8'hF4;
    localparam bit             VS_POL  = 1'b0;
    localparam bit             VS_ACT  = VS_POL;
    localparam bit             VS_IDLE = !VS_POL;

    function automatic logic [NR*32-1:0] f_rst_vals();
        logic [NR*32-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++)
            if (k != 1 && k != 2) v[32*k +: 32] = 32'hC0DE_0000 | 32'(k * 17);
        return v;
    endfunction
    localparam logic [NR*32-1:0] RST_VALS = f_rst_vals();

    logic              clk_i, rst_i;
    logic              wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [AW-1:0]     wb_adr_i;
    logic [31:0]       wb_dat_i, wb_dat_o;
    logic              wb_ack_o, wb_stall_o, vs_async, irq_o;
    logic [NR*32-1:0]  regs_o;

    vga_ctrl_regs #(
        .NREGS(NR), .AW(AW), .RESET_VALS(RST_VALS), .SHADOW_MASK(SHADOW), .VS_POL(VS_POL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .vs_async(vs_async), .regs_o(regs_o), .irq_o(irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]   m_pend [NR];
    logic [31:0]   m_act  [NR];
    logic [NR-1:0] m_dirty;
    logic          m_vblank, m_irqen, m_vs_lvl;
    logic [15:0]   m_frame;

    task automatic m_reset();
        for (int k = 0; k < NR; k++) begin
            m_pend[k] = RST_VALS[32*k +: 32];
            m_act[k]  = RST_VALS[32*k +: 32];
        end
        m_dirty = '0; m_vblank = 0; m_irqen = 0; m_vs_lvl = 0; m_frame = 0;
    endtask

    function automatic logic [NR*32-1:0] m_regs();
        logic [NR*32-1:0] v;
        for (int k = 0; k < NR; k++) v[32*k +: 32] = m_act[k];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx < NR)      return m_pend[idx];
        if (idx == NR)     return {m_frame, 13'd0, m_vs_lvl, |m_dirty, m_vblank};
        if (idx == NR + 1) return {31'd0, m_irqen};
        return 32'd0;
    endfunction

    function automatic logic m_irq();
        return m_vblank & m_irqen;
    endfunction

    task automatic m_write(input int idx, input logic [3:0] sel, input logic [31:0] dat,
                           input bit vs_now);
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_pend[idx][8*b +: 8] = dat[8*b +: 8];
            if (SHADOW[idx]) m_dirty[idx] = 1'b1;
            else             m_act[idx] = m_pend[idx];
        end else if (idx == NR) begin
            if (sel[0] && dat[0] && !vs_now) m_vblank = 1'b0;
        end else if (idx == NR + 1) begin
            if (sel[0]) m_irqen = dat[0];
        end
    endtask

    task automatic m_vstart();
        for (int k = 0; k < NR; k++) if (SHADOW[k] && m_dirty[k]) m_act[k] = m_pend[k];
        m_dirty = '0; m_vblank = 1'b1; m_frame = m_frame + 16'd1;
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_drive(input bit we, input int idx, input logic [3:0] sel,
                             input logic [31:0] dat);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
        wb_adr_i = AW'(idx << 2) | AW'($urandom_range(0, 3));
    endtask

    task automatic bus_finish(input bit chk_rd, input logic [31:0] exp_rd, input string tag,
                              output logic [31:0] rd);
        @(negedge clk_i);
        chk({tag, "_ack"}, wb_ack_o, 1'b1);
        chk({tag, "_stall"}, wb_stall_o, 1'b1);
        rd = wb_dat_o;
        if (chk_rd) chk({tag, "_dat"}, wb_dat_o, exp_rd);
        chk({tag, "_regs"}, regs_o, m_regs());
        wb_stb_i = 0;
        @(negedge clk_i);
        chk({tag, "_ack_end"}, wb_ack_o, 1'b0);
        chk({tag, "_irq"}, irq_o, m_irq());
        wb_cyc_i = 0; wb_we_i = 0;
    endtask

    task automatic xfer(input bit we, input int idx, input logic [3:0] sel,
                        input logic [31:0] dat, input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        exp_rd = m_read(idx);
        @(negedge clk_i);
        bus_drive(we, idx, sel, dat);
        if (we) m_write(idx, sel, dat, 1'b0);
        bus_finish(!we, exp_rd, tag, rd);
    endtask

    // Commit is expected on the third clock edge after vs_async goes active
    task automatic vs_assert();
        @(negedge clk_i); vs_async = VS_ACT;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("vs_pre_commit", regs_o, m_regs());
        m_vstart();
        @(negedge clk_i);
        chk("vs_commit", regs_o, m_regs());
        m_vs_lvl = 1'b1;
    endtask

    task automatic vs_release();
        @(negedge clk_i); vs_async = VS_IDLE;
        repeat (4) @(negedge clk_i);
        m_vs_lvl = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, e0, v;
        int          idx, op;

        rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; vs_async = VS_IDLE;
        m_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_ack", wb_ack_o, 1'b0);
        chk("rst_stall", wb_stall_o, 1'b0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_regs", regs_o, RST_VALS);
        rst_i = 0;
        for (int i = 0; i <= NR + 1; i++) xfer(0, i, 4'hF, 0, "rst_rd", rd);

        // byte-lane write to a non-shadowed register
        xfer(1, 1, 4'b0101, 32'hDEADBEEF, "wr_r1", rd);
        xfer(0, 1, 4'hF, 0, "rd_r1", rd);
        chk("r1_val", rd, 32'h00AD00EF);
        chk("r1_regs_o", regs_o[63:32], 32'h00AD00EF);

        // shadowed register only reaches regs_o at vsync
        xfer(1, 2, 4'hF, 32'h1234, "wr_r2", rd);
        xfer(0, 2, 4'hF, 0, "rd_r2", rd);
        chk("r2_rdback", rd, 32'h1234);
        chk("r2_regs_hold", regs_o[95:64], 32'h0);
        xfer(0, NR, 4'hF, 0, "rd_st_dirty", rd);
        chk("st_dirty", rd[1], 1'b1);
        vs_assert();
        chk("r2_commit", regs_o[95:64], 32'h1234);
        xfer(0, NR, 4'hF, 0, "rd_st_vs", rd);
        chk("st_vs_lvl", rd[2], 1'b1);
        vs_release();
        xfer(0, NR, 4'hF, 0, "rd_st_clean", rd);
        chk("st_clean", rd[1], 1'b0);
        chk("st_frame1", rd[31:16], 16'd1);

        // write landing on the exact vstart edge
        xfer(1, 2, 4'hF, 32'h0000AAAA, "wr_r2b", rd);
        @(negedge clk_i); vs_async = VS_ACT;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("co_pre", regs_o, m_regs());
        bus_drive(1, 2, 4'hF, 32'h55556666);
        m_vstart();
        m_write(2, 4'hF, 32'h55556666, 1'b1);
        bus_finish(0, 0, "co_wr", rd);
        chk("co_old_commit", regs_o[95:64], 32'h0000AAAA);
        m_vs_lvl = 1'b1;
        vs_release();
        xfer(0, 2, 4'hF, 0, "co_rd", rd);
        xfer(0, NR, 4'hF, 0, "co_st", rd);
        chk("co_dirty", rd[1], 1'b1);
        vs_assert();
        vs_release();
        chk("co_new_commit", regs_o[95:64], 32'h55556666);

        // interrupt
        xfer(1, NR, 4'h1, 32'h1, "w1c0", rd);
        xfer(1, NR + 1, 4'h1, 32'h1, "irqen", rd);
        chk("irq_idle", irq_o, 1'b0);
        vs_assert();
        vs_release();
        chk("irq_set", irq_o, 1'b1);
        @(negedge clk_i); vs_async = VS_ACT;
        @(negedge clk_i);
        @(negedge clk_i);
        bus_drive(1, NR, 4'h1, 32'h1);
        m_vstart();
        m_write(NR, 4'h1, 32'h1, 1'b1);
        bus_finish(0, 0, "co_w1c", rd);
        chk("irq_co_w1c", irq_o, 1'b1);
        m_vs_lvl = 1'b1;
        vs_release();
        xfer(1, NR, 4'h1, 32'h1, "w1c1", rd);
        chk("irq_clr", irq_o, 1'b0);

        // back-to-back strobes
        e0 = m_read(0);
        @(negedge clk_i);
        bus_drive(0, 0, 4'hF, 0);
        @(negedge clk_i);
        chk("b2b_ack1", wb_ack_o, 1'b1);
        chk("b2b_dat1", wb_dat_o, e0);
        chk("b2b_stall1", wb_stall_o, 1'b1);
        wb_adr_i = AW'(1 << 2);
        @(negedge clk_i);
        chk("b2b_hold_ack", wb_ack_o, 1'b0);
        chk("b2b_hold_stall", wb_stall_o, 1'b0);
        @(negedge clk_i);
        chk("b2b_ack2", wb_ack_o, 1'b1);
        chk("b2b_dat2", wb_dat_o, m_read(1));
        wb_stb_i = 0;
        @(negedge clk_i);
        wb_cyc_i = 0;

        // cycle dropped during ACK: no ack, write still done
        v = $urandom;
        @(negedge clk_i);
        bus_drive(1, 3, 4'hF, v);
        m_write(3, 4'hF, v, 1'b0);
        @(negedge clk_i);
        wb_cyc_i = 0; wb_stb_i = 0;
        #1;
        chk("abort_ack", wb_ack_o, 1'b0);
        chk("abort_regs", regs_o, m_regs());
        wb_we_i = 0;
        xfer(0, 3, 4'hF, 0, "abort_rd", rd);

        // randomised traffic
        for (int i = 0; i < 200; i++) begin
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, NR + 5);
            if (op <= 5)      xfer(1, idx, 4'($urandom), $urandom, "rnd_wr", rd);
            else if (op <= 8) xfer(0, idx, 4'hF, 0, "rnd_rd", rd);
            else begin
                vs_assert();
                vs_release();
            end
            chk("rnd_regs", regs_o, m_regs());
            chk("rnd_irq", irq_o, m_irq());
        end
        for (int i = 0; i <= NR + 1; i++) xfer(0, i, 4'hF, 0, "final_rd", rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
